// File: rtl/stream_mux_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module  : stream_mux_arb_pkg
// Brief   : Shared types and helpers for the stream_mux_arb block.
// Revision: 1.0 - initial release
// ============================================================================
package stream_mux_arb_pkg;

  typedef enum logic {MODE_FIXED = 1'b0, MODE_RR = 1'b1} mode_e;

  typedef enum logic {ARB_IDLE = 1'b0, ARB_LOCKED = 1'b1} arb_state_e;

  // Widest one-hot vector onehot2idx accepts; callers zero-extend into it.
  localparam int OH_MAX = 64;

  function automatic int onehot2idx(input logic [OH_MAX-1:0] oh);
    int idx;
    idx = 0;
    for (int i = 0; i < OH_MAX; i++) begin
      if (oh[i]) idx = i;
    end
    return idx;
  endfunction

endpackage
`default_nettype wire

// File: rtl/stream_mux_arb_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : rr_arbiter
// Brief   : Combinational round-robin arbiter; first requester at or after ptr.
// Revision: 1.0 - initial release
// ============================================================================
module rr_arbiter
  import stream_mux_arb_pkg::*;
#(
  parameter int N = 8,
  localparam int SELW = $clog2(N)
) (
  input  logic [N-1:0]    req,
  input  logic [SELW-1:0] ptr,
  output logic [N-1:0]    gnt,
  output logic [SELW-1:0] gnt_idx
);

  always_comb begin
    logic            found;
    logic [SELW-1:0] cand;
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    cand    = '0;
    for (int k = 0; k < N; k++) begin
      cand = SELW'((int'(ptr) + k) % N);
      if (!found && req[cand]) begin
        gnt[cand] = 1'b1;
        gnt_idx   = cand;
        found     = 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/stream_mux_arb.sv
`default_nettype none
// ============================================================================
// Module  : stream_mux_arb
// Brief   : N:1 valid/ready stream mux with fixed-select or round-robin
//           arbitration and a registered output stage. Defining
//           STREAM_MUX_ARB_LOCK_EN adds in_last/out_last and packet locking.
// Revision: 1.0 - initial release
// ============================================================================
module stream_mux_arb
  import stream_mux_arb_pkg::*;
#(
  parameter int N = 8,
  parameter int W = 6,
  localparam int SELW = $clog2(N)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            mode,
  input  logic [SELW-1:0] sel,
  input  logic [N*W-1:0]  in_data,
  input  logic [N-1:0]    in_valid,
  output logic [N-1:0]    in_ready,
`ifdef STREAM_MUX_ARB_LOCK_EN
  input  logic [N-1:0]    in_last,
  output logic            out_last,
`endif
  output logic [W-1:0]    out_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [SELW-1:0] out_src
);

  logic [W-1:0]    out_data_q,  out_data_d;
  logic            out_valid_q, out_valid_d;
  logic [SELW-1:0] out_src_q,   out_src_d;
  logic [SELW-1:0] rr_ptr_q,    rr_ptr_d;

  logic [N-1:0]      rr_gnt;
  logic [SELW-1:0]   rr_idx;
  logic [N-1:0]      sel_gnt;
  logic [N-1:0]      lock_gnt;
  logic [N-1:0]      fixed_side;
  logic [OH_MAX-1:0] fixed_wide;
  logic [N-1:0]      grant;
  logic [N-1:0]      ready;
  logic              locked;
  logic              use_rr;
  logic              load;
  logic              xfer;
  logic              xfer_last;
  logic [SELW-1:0]   xfer_idx;
  logic [W-1:0]      xfer_data;

  rr_arbiter #(.N(N)) u_rr (
    .req     (in_valid),
    .ptr     (rr_ptr_q),
    .gnt     (rr_gnt),
    .gnt_idx (rr_idx)
  );

  // Out-of-range sel matches no channel, so it can never grant.
  always_comb begin
    sel_gnt = '0;
    for (int i = 0; i < N; i++) begin
      sel_gnt[i] = in_valid[i] && (sel == SELW'(i));
    end
  end

`ifdef STREAM_MUX_ARB_LOCK_EN
  arb_state_e      state_q,   state_d;
  logic [SELW-1:0] lock_ch_q, lock_ch_d;
  logic            out_last_q, out_last_d;

  assign locked    = (state_q == ARB_LOCKED);
  assign xfer_last = |(ready & in_last);
  assign out_last  = out_last_q;

  always_comb begin
    lock_gnt = '0;
    for (int i = 0; i < N; i++) begin
      lock_gnt[i] = in_valid[i] && (lock_ch_q == SELW'(i));
    end
  end

  always_comb begin
    state_d    = state_q;
    lock_ch_d  = lock_ch_q;
    out_last_d = out_last_q;
    if (xfer) out_last_d = xfer_last;
    case (state_q)
      ARB_IDLE: begin
        if (xfer && !xfer_last) begin
          state_d   = ARB_LOCKED;
          lock_ch_d = xfer_idx;
        end
      end
      ARB_LOCKED: begin
        if (xfer && xfer_last) state_d = ARB_IDLE;
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ARB_IDLE;
      lock_ch_q  <= '0;
      out_last_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      lock_ch_q  <= lock_ch_d;
      out_last_q <= out_last_d;
    end
  end
`else
  assign locked    = 1'b0;
  assign lock_gnt  = '0;
  assign xfer_last = 1'b1;
`endif

  assign load       = !out_valid_q || out_ready;
  assign use_rr     = (mode_e'(mode) == MODE_RR) && !locked;
  assign fixed_side = locked ? lock_gnt : sel_gnt;
  assign grant      = use_rr ? rr_gnt : fixed_side;
  assign ready      = (reset || !load) ? '0 : grant;
  assign xfer       = |ready;
  assign in_ready   = ready;

  always_comb begin
    fixed_wide         = '0;
    fixed_wide[N-1:0]  = fixed_side;
  end

  assign xfer_idx = use_rr ? rr_idx : SELW'(onehot2idx(fixed_wide));

  // ready is one-hot or zero, so an OR-reduction acts as the data mux.
  always_comb begin
    xfer_data = '0;
    for (int i = 0; i < N; i++) begin
      if (ready[i]) xfer_data = xfer_data | in_data[i*W +: W];
    end
  end

  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_src_d   = out_src_q;
    rr_ptr_d    = rr_ptr_q;
    if (xfer) begin
      out_valid_d = 1'b1;
      out_data_d  = xfer_data;
      out_src_d   = xfer_idx;
      if (xfer_last) begin
        rr_ptr_d = (xfer_idx == SELW'(N-1)) ? '0 : xfer_idx + SELW'(1);
      end
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_src_q   <= '0;
      rr_ptr_q    <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_src_q   <= out_src_d;
      rr_ptr_q    <= rr_ptr_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign out_src   = out_src_q;

endmodule
`default_nettype wire

// File: tb/tb_stream_mux_arb.sv
`default_nettype none
// ============================================================================
// Module  : tb_stream_mux_arb
// Brief   : Self-checking bench for stream_mux_arb (N=8, W=6) with a
//           behavioural model; covers STREAM_MUX_ARB_LOCK_EN when defined.
// Revision: 1.0 - initial release
// ============================================================================
module tb_stream_mux_arb;

  localparam int NN = 8;
  localparam int WW = 6;

  logic        clk = 1'b0;
  logic        reset;
  logic        mode;
  logic [2:0]  sel;
  logic [47:0] in_data;
  logic [7:0]  in_valid;
  logic [7:0]  in_ready;
  logic [5:0]  out_data;
  logic        out_valid;
  logic        out_ready;
  logic [2:0]  out_src;
`ifdef STREAM_MUX_ARB_LOCK_EN
  logic [7:0]  in_last;
  logic        out_last;
  logic [5:0]  d6_in_last = '0;
  logic        d6_out_last;
`endif

  // Second instance with N=6 so that sel values >= N can be exercised.
  logic [2:0]  d6_sel;
  logic [35:0] d6_in_data;
  logic [5:0]  d6_in_ready;
  logic [5:0]  d6_out_data;
  logic        d6_out_valid;
  logic [2:0]  d6_out_src;

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  stream_mux_arb #(.N(NN), .W(WW)) dut (
    .clk(clk), .reset(reset), .mode(mode), .sel(sel),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
`ifdef STREAM_MUX_ARB_LOCK_EN
    .in_last(in_last), .out_last(out_last),
`endif
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_src(out_src)
  );

  stream_mux_arb #(.N(6), .W(6)) dut6 (
    .clk(clk), .reset(reset), .mode(1'b0), .sel(d6_sel),
    .in_data(d6_in_data), .in_valid(6'h3F), .in_ready(d6_in_ready),
`ifdef STREAM_MUX_ARB_LOCK_EN
    .in_last(d6_in_last), .out_last(d6_out_last),
`endif
    .out_data(d6_out_data), .out_valid(d6_out_valid), .out_ready(1'b1),
    .out_src(d6_out_src)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Behavioural model of the output register, round-robin pointer and lock.
  bit       m_valid = 0;
  bit [5:0] m_data  = 0;
  int       m_src   = 0;
  int       m_ptr   = 0;
  bit       m_locked = 0;
  int       m_lock_ch = 0;
  bit       m_last  = 0;

  function automatic logic [7:0] exp_grant();
    logic [7:0] g;
    int c;
    g = '0;
    if (reset) return g;
    if (m_valid && !out_ready) return g;
    if (m_locked) begin
      if (in_valid[m_lock_ch]) g[m_lock_ch] = 1'b1;
      return g;
    end
    if (mode == 1'b0) begin
      if (int'(sel) < NN && in_valid[sel]) g[sel] = 1'b1;
    end else begin
      for (int k = 0; k < NN; k++) begin
        c = (m_ptr + k) % NN;
        if (in_valid[c]) begin
          g[c] = 1'b1;
          break;
        end
      end
    end
    return g;
  endfunction

  always @(posedge clk) begin
    logic [7:0] g;
    int c;
    bit lst;
    g = exp_grant();
    if (reset) begin
      m_valid = 0; m_data = 0; m_src = 0; m_ptr = 0; m_locked = 0; m_lock_ch = 0; m_last = 0;
    end else if (g != 0) begin
      c = 0;
      for (int i = 0; i < NN; i++) if (g[i]) c = i;
      m_valid = 1;
      m_data  = in_data[c*WW +: WW];
      m_src   = c;
`ifdef STREAM_MUX_ARB_LOCK_EN
      lst = in_last[c];
`else
      lst = 1'b1;
`endif
      m_last = lst;
      if (!m_locked && !lst) begin
        m_locked  = 1;
        m_lock_ch = c;
      end else begin
        if (m_locked && lst) m_locked = 0;
        if (lst) m_ptr = (c + 1) % NN;
      end
    end else if (out_ready) begin
      m_valid = 0;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("model_in_ready", 32'(in_ready), 32'(exp_grant()));
      chk("model_out_valid", 32'(out_valid), 32'(m_valid));
      if (m_valid) begin
        chk("model_out_data", 32'(out_data), 32'(m_data));
        chk("model_out_src", 32'(out_src), m_src);
`ifdef STREAM_MUX_ARB_LOCK_EN
        chk("model_out_last", 32'(out_last), 32'(m_last));
`endif
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [2:0] exp4 [3];
    exp4 = '{3'd7, 3'd1, 3'd7};
    reset = 1'b1; mode = 1'b0; sel = 3'd0; out_ready = 1'b0;
    in_valid = 8'hFF;
    d6_sel = 3'd7;
`ifdef STREAM_MUX_ARB_LOCK_EN
    in_last = '0;
`endif
    for (int i = 0; i < NN; i++) in_data[i*WW +: WW] = 6'((i + 1) * 9);
    for (int i = 0; i < 6; i++) d6_in_data[i*6 +: 6] = 6'((i + 1) * 9);

    // Reset state and in_ready gating during reset
    cyc();
    chk_en = 1'b1;
    @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 0);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_out_data", 32'(out_data), 0);
    chk("rst_out_src", 32'(out_src), 0);

    // Fixed select of channel 3
    cyc(); reset = 1'b0; sel = 3'd3; out_ready = 1'b1;
    @(negedge clk);
    chk("t1_in_ready", 32'(in_ready), 32'h08);
    cyc(); @(negedge clk);
    chk("t1_out_data", 32'(out_data), 36);
    chk("t1_out_src", 32'(out_src), 3);

    // Fixed select of an invalid channel drains the stage
    cyc(); sel = 3'd5; in_valid = 8'hDF;
    @(negedge clk);
    chk("t2_in_ready", 32'(in_ready), 0);
    chk("t2_pending", 32'(out_valid), 1);
    cyc(); @(negedge clk);
    chk("t2_empty", 32'(out_valid), 0);
    chk("t2_n6_sel7_ready", 32'(d6_in_ready), 0);
    chk("t2_n6_sel7_valid", 32'(d6_out_valid), 0);
    cyc(); d6_sel = 3'd5;
    @(negedge clk);
    chk("t2_n6_sel5_ready", 32'(d6_in_ready), 32'h20);
    cyc(); @(negedge clk);
    chk("t2_n6_sel5_src", 32'(d6_out_src), 5);
    chk("t2_n6_sel5_data", 32'(d6_out_data), 54);

    // Round-robin wrap with all channels valid
    cyc(); reset = 1'b1;
    cyc(); reset = 1'b0; mode = 1'b1; in_valid = 8'hFF;
    @(negedge clk);
    chk("t3_first_ready", 32'(in_ready), 32'h01);
    for (int k = 0; k < 10; k++) begin
      cyc(); @(negedge clk);
      chk("t3_rr_src", 32'(out_src), k % 8);
    end

    // Sparse round-robin starting from pointer 2
    #1 in_valid = 8'b1000_0010;
    #1 chk("t4_in_ready", 32'(in_ready), 32'h80);
    for (int j = 0; j < 3; j++) begin
      cyc(); @(negedge clk);
      chk("t4_rr_src", 32'(out_src), 32'(exp4[j]));
    end
    chk("t4_data", 32'(out_data), 8);

    // Backpressure holds the beat; release with no bubble
    #1 out_ready = 1'b0;
    for (int j = 0; j < 3; j++) begin
      cyc(); @(negedge clk);
      chk("t5_hold_src", 32'(out_src), 7);
      chk("t5_hold_data", 32'(out_data), 8);
      chk("t5_hold_ready", 32'(in_ready), 0);
    end
    #1 out_ready = 1'b1; in_valid = 8'h04;
    #1 chk("t5_go_ready", 32'(in_ready), 32'h04);
    cyc(); @(negedge clk);
    chk("t5_new_src", 32'(out_src), 2);
    chk("t5_new_data", 32'(out_data), 27);
    chk("t5_new_valid", 32'(out_valid), 1);

    // Reset while full
    #1 reset = 1'b1;
    cyc(); @(negedge clk);
    chk("t6_valid", 32'(out_valid), 0);
    chk("t6_ready", 32'(in_ready), 0);
    #1 reset = 1'b0; in_valid = 8'hFF; mode = 1'b1;
    #1 chk("t6_ptr_zero", 32'(in_ready), 32'h01);

`ifdef STREAM_MUX_ARB_LOCK_EN
    // Channel 2 holds the lock for a 3-beat packet while channel 0 waits
    #1 mode = 1'b0; sel = 3'd2; in_valid = 8'h05; in_last = 8'h00;
    #1 chk("lk_first_ready", 32'(in_ready), 32'h04);
    cyc(); mode = 1'b1;
    @(negedge clk);
    chk("lk_src1", 32'(out_src), 2);
    chk("lk_ready1", 32'(in_ready), 32'h04);
    cyc(); in_last = 8'h04;
    @(negedge clk);
    chk("lk_src2", 32'(out_src), 2);
    chk("lk_last2", 32'(out_last), 0);
    cyc(); in_last = 8'h00;
    @(negedge clk);
    chk("lk_src3", 32'(out_src), 2);
    chk("lk_last3", 32'(out_last), 1);
    chk("lk_unlock_ready", 32'(in_ready), 32'h01);
    cyc(); @(negedge clk);
    chk("lk_src4", 32'(out_src), 0);
`endif

    // Randomised traffic against the model
    for (int n = 0; n < 3000; n++) begin
      cyc();
      reset     = ($urandom_range(0, 63) == 0);
      if ($urandom_range(0, 7) == 0) mode = 1'($urandom_range(0, 1));
      sel       = 3'($urandom_range(0, 7));
      in_valid  = 8'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      in_data   = 48'({$urandom, $urandom});
`ifdef STREAM_MUX_ARB_LOCK_EN
      in_last   = 8'($urandom) & 8'($urandom);
`endif
    end
    cyc();
    chk_en = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
